inst_fetch_seq: RTL and testbench

//  Instruction fetch/sequencer for the SIMPLE 16-bit core; the producer side of the decoder's inst input.

---
 rtl/inst_fetch_seq.sv | 122 ++++++++++++
 tb/tb_inst_fetch_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_seq.sv
// Instruction fetch/sequencer for the SIMPLE 16-bit core: holds the PC, fetches one
// word per execution step, resolves branches against S/Z/V and stops on halt.
module inst_fetch_seq #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [15:0]          NOP_INST = 16'hC0E0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  input  logic              exec_done,
  input  logic [2:0]        br_code,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flag_s,
  input  logic              flag_z,
  input  logic              flag_v,
  input  logic              halt_n,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              halted_q, halted_d;
  logic              br_taken;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    br_taken = 1'b0;
    unique case (br_code)
      3'b000:  br_taken = flag_z;
      3'b001:  br_taken = flag_s ^ flag_v;
      3'b010:  br_taken = flag_z | (flag_s ^ flag_v);
      3'b011:  br_taken = ~flag_z;
      3'b100:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    halted_d     = halted_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_LOAD;
      end
      // Memory answers one cycle after the address; capture it here so the
      // pulse lines up with the first EXEC cycle.
      S_LOAD: begin
        inst_d       = imem_rdata;
        inst_valid_d = 1'b1;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (!halt_n) begin
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end else begin
            pc_d    = br_taken ? br_target : pc_inc;
            state_d = S_REQ;
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_d     = pc_inc;
          halted_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_plus1   = pc_inc;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Bench for inst_fetch_seq: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_inst_fetch_seq;

  logic        clk = 1'b0;
  logic        rst, start, exec_done, flag_s, flag_z, flag_v, halt_n;
  logic [2:0]  br_code;
  logic [15:0] br_target, imem_addr, imem_rdata, inst, pc, pc_plus1;
  logic        inst_valid, halted;

  int checks = 0;
  int errors = 0;

  inst_fetch_seq #(.ADDR_W(16), .RESET_PC(16'h0000), .NOP_INST(16'hC0E0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus1(pc_plus1),
    .exec_done(exec_done), .br_code(br_code), .br_target(br_target),
    .flag_s(flag_s), .flag_z(flag_z), .flag_v(flag_v),
    .halt_n(halt_n), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_at(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    return a ^ 16'h5A00;
  endfunction

  always @(posedge clk) imem_rdata <= mem_at(imem_addr);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic taken(input logic [2:0] c, input logic s, input logic z, input logic v);
    case (c)
      3'b100:  return 1'b1;
      3'b000:  return z;
      3'b001:  return s ^ v;
      3'b010:  return z | (s ^ v);
      3'b011:  return ~z;
      default: return 1'b0;
    endcase
  endfunction

  // Model: what the core is doing, not how the sequencer encodes it.
  // An accepted start/exec_done makes the next word appear 3 cycles later.
  typedef enum {M_IDLE, M_FETCH, M_EXEC, M_HALT} mode_t;
  mode_t       m_mode;
  logic [15:0] m_pc, m_inst;
  logic        m_valid, m_halted, model_live = 1'b0;
  int          m_wait;

  always @(posedge clk) begin
    m_valid = 1'b0;
    if (rst) begin
      model_live = 1'b1;
      m_mode = M_IDLE; m_pc = 16'h0000; m_inst = 16'hC0E0; m_halted = 1'b0; m_wait = 0;
    end else if (model_live) begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_FETCH; m_wait = 2; end
        M_FETCH: begin
          if (m_wait == 1) begin
            m_inst = mem_at(m_pc); m_valid = 1'b1; m_mode = M_EXEC;
          end else m_wait--;
        end
        M_EXEC: if (exec_done) begin
          if (!halt_n) begin
            m_mode = M_HALT; m_halted = 1'b1;
          end else begin
            m_pc = taken(br_code, flag_s, flag_z, flag_v) ? br_target : m_pc + 16'd1;
            m_mode = M_FETCH; m_wait = 2;
          end
        end
        M_HALT: if (start) begin
          m_pc = m_pc + 16'd1; m_halted = 1'b0; m_mode = M_FETCH; m_wait = 2;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc_plus1", pc_plus1, m_pc + 16'd1);
      chk("inst", inst, m_inst);
      chk("inst_valid", {15'd0, inst_valid}, {15'd0, m_valid});
      chk("halted", {15'd0, halted}, {15'd0, m_halted});
    end
  end

  task automatic wait_valid(output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (inst_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("wait_valid_timeout", 16'd0, 16'd1);
  endtask

  // Called at a negedge inside EXEC; exec_done is held for one rising edge.
  task automatic do_exec(input logic [2:0] c, input logic s, input logic z, input logic v,
                         input logic [15:0] tgt, input logic hn);
    br_code = c; flag_s = s; flag_z = z; flag_v = v; br_target = tgt; halt_n = hn;
    exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0; halt_n = 1'b1; br_code = 3'b111;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; exec_done = 1'b0; br_code = 3'b111; br_target = '0;
    flag_s = 1'b0; flag_z = 1'b0; flag_v = 1'b0; halt_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_inst", inst, 16'hC0E0);
    chk("rst_valid", {15'd0, inst_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);

    rst = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(n);
    chk("first_latency", 16'(n), 16'd3);
    chk("first_inst", inst, 16'h1234);
    chk("first_pc", pc, 16'h0000);

    do_exec(3'b111, 0, 0, 0, 16'h0000, 1'b1);
    chk("seq_addr", imem_addr, 16'h0001);
    wait_valid(n);
    chk("seq_latency", 16'(n), 16'd3);
    chk("seq_pc", pc, 16'h0001);
    chk("seq_inst", inst, 16'h5A01);

    do_exec(3'b000, 0, 1, 0, 16'h0040, 1'b1);
    wait_valid(n);
    chk("be_taken_pc", pc, 16'h0040);
    do_exec(3'b000, 0, 0, 0, 16'h0080, 1'b1);
    wait_valid(n);
    chk("be_not_taken_pc", pc, 16'h0041);
    do_exec(3'b001, 1, 0, 1, 16'h0100, 1'b1);
    wait_valid(n);
    chk("blt_not_taken_pc", pc, 16'h0042);
    do_exec(3'b010, 1, 0, 0, 16'h0005, 1'b1);
    wait_valid(n);
    chk("ble_taken_pc", pc, 16'h0005);
    chk("ble_inst", inst, 16'h5A05);

    do_exec(3'b100, 0, 0, 0, 16'h0900, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_flag", {15'd0, halted}, 16'd1);
      chk("halt_pc", pc, 16'h0005);
      chk("halt_no_valid", {15'd0, inst_valid}, 16'd0);
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(n);
    chk("resume_latency", 16'(n), 16'd3);
    chk("resume_pc", pc, 16'h0006);
    chk("resume_halted", {15'd0, halted}, 16'd0);

    do_exec(3'b011, 0, 0, 0, 16'hFFFF, 1'b1);
    wait_valid(n);
    chk("bne_pc", pc, 16'hFFFF);
    chk("ffff_plus1", pc_plus1, 16'h0000);
    do_exec(3'b101, 1, 1, 1, 16'h1111, 1'b1);
    wait_valid(n);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_inst", inst, 16'h1234);

    exec_done = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_inst", inst, 16'hC0E0);
    exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_no_valid", {15'd0, inst_valid}, 16'd0);
    end
    exec_done = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
